// File: rtl/lamp_sequencer.sv
// lamp_sequencer: picks a lamp target from time of day and room size, then drives it.
// Define LAMP_SEQ_RAMP_EN for one-lamp-per-step ramping; otherwise the count jumps.
module lamp_sequencer #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned MAX_LAMPS   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  tcode,
  input  logic [3:0]  ulight,
  input  logic [3:0]  length,
  output logic [14:0] lamp_en,
  output logic [3:0]  active_count,
  output logic        busy,
  output logic        done,
  output logic        tcode_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_LAMPS);

  if (STEP_CYCLES < 1 || STEP_CYCLES > 255) begin : g_bad_step
    $error("STEP_CYCLES out of range");
  end

  logic [3:0]  raw;
  logic [3:0]  target_d, target_q;
  logic        err_d, err_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [14:0] lamp_d, lamp_q;
  logic        done_d, done_q;
  logic        busy_d, busy_q;

  always_comb begin
    raw = '0;
    case (tcode)
      4'b0100: raw = {2'b00, length[3:2]};
      4'b1000: raw = ulight;
      default: raw = '0;
    endcase
    if (!en) raw = '0;
    target_d = (raw > MAX_CNT) ? MAX_CNT : raw;
    err_d = (tcode == 4'b0) || ((tcode & (tcode - 4'd1)) != 4'b0);
  end

`ifdef LAMP_SEQ_RAMP_EN
  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  localparam logic [7:0] RELOAD = 8'(STEP_CYCLES - 1);

  state_t     state_d, state_q;
  logic [7:0] timer_d, timer_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (target_q != cnt_q) begin
          state_d = (target_q > cnt_q) ? RAMP_UP : RAMP_DOWN;
          timer_d = RELOAD;
        end
      end
      default: begin
        // Target caught up with us between steps: stop without stepping.
        if (target_q == cnt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_q != 8'd0) begin
          timer_d = timer_q - 8'd1;
        end else begin
          cnt_d   = (target_q > cnt_q) ? cnt_q + 4'd1 : cnt_q - 4'd1;
          timer_d = RELOAD;
          if (cnt_d == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = (target_q > cnt_d) ? RAMP_UP : RAMP_DOWN;
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end
`else
  always_comb begin
    cnt_d  = target_q;
    done_d = (target_q != cnt_q);
    busy_d = 1'b0;
  end
`endif

  assign lamp_d = 15'((16'd1 << cnt_d) - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      lamp_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      lamp_q   <= lamp_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign lamp_en      = lamp_q;
  assign active_count = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tcode_err    = err_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// tb_lamp_sequencer: directed stimulus with a done-triggered scoreboard.
// Covers both the LAMP_SEQ_RAMP_EN build and the default jump build.
module tb_lamp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  tcode = 4'b0001;
  logic [3:0]  ulight = 4'd0;
  logic [3:0]  length = 4'd0;
  logic [14:0] lamp_en, lamp_en8;
  logic [3:0]  cnt, cnt8;
  logic        busy, done, terr;
  logic        busy8, done8, terr8;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  typedef struct packed {
    logic [3:0]  c;
    logic [14:0] l;
  } exp_t;
  exp_t q[$];

  lamp_sequencer #(.STEP_CYCLES(4), .MAX_LAMPS(15)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tcode(tcode),
    .ulight(ulight), .length(length), .lamp_en(lamp_en),
    .active_count(cnt), .busy(busy), .done(done), .tcode_err(terr)
  );

  lamp_sequencer #(.STEP_CYCLES(1), .MAX_LAMPS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .tcode(tcode),
    .ulight(ulight), .length(length), .lamp_en(lamp_en8),
    .active_count(cnt8), .busy(busy8), .done(done8), .tcode_err(terr8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected settle point.
  always @(negedge clk) begin
    if (rst_n && done) begin
      ndone++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual count=%0d required no pulse", cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_count", 32'(cnt), 32'(e.c));
        chk("done_lamp", 32'(lamp_en), 32'(e.l));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic [14:0] l);
    exp_t e;
    e.c = c;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int max);
    int start;
    bit seen;
    start = ndone;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      cyc(1);
      if (ndone != start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s actual=no done within %0d cycles required=done", name, max);
    end
  endtask

  task automatic wait_cnt(input string name, input logic [3:0] v, input int max);
    bit seen;
    seen = (cnt == v);
    for (int i = 0; i < max && !seen; i++) begin
      cyc(1);
      if (cnt == v) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, cnt, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_lamp", 32'(lamp_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_terr", 32'(terr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

`ifdef LAMP_SEQ_RAMP_EN
    // Night, 3 lamps from 0
    tcode = 4'b1000; ulight = 4'd3; en = 1'b1;
    push(4'd3, 15'h0007);
    cyc(1);
    chk("ramp_busy_1cyc", 32'(busy), 32'd0);
    cyc(1);
    chk("ramp_busy_2cyc", 32'(busy), 32'd1);
    cyc(4);
    chk("ramp_step1", 32'(cnt), 32'd1);
    cyc(4);
    chk("ramp_step2", 32'(cnt), 32'd2);
    cyc(4);
    chk("ramp_step3", 32'(cnt), 32'd3);
    chk("ramp_lamp3", 32'(lamp_en), 32'h0007);
    cyc(1);
    chk("ramp_done_single", 32'(done), 32'd0);

    // Evening, length 9 -> 2, then morning -> 0
    tcode = 4'b0100; length = 4'd9;
    push(4'd2, 15'h0003);
    wait_done("eve_done", 20);
    tcode = 4'b0001;
    push(4'd0, 15'h0000);
    wait_done("morn_done", 20);
    cyc(4);

    // Drop target mid-ramp: next step heads back, no overshoot
    tcode = 4'b1000; ulight = 4'd5;
    wait_cnt("drop_reach3", 4'd3, 30);
    ulight = 4'd2;
    push(4'd2, 15'h0003);
    wait_done("drop_done", 20);
    cyc(6);
    chk("drop_hold", 32'(cnt), 32'd2);
    chk("drop_idle", 32'(busy), 32'd0);

    // Target meets count between steps: immediate stop
    ulight = 4'd5;
    wait_cnt("meet_reach3", 4'd3, 30);
    ulight = 4'd3;
    push(4'd3, 15'h0007);
    wait_done("meet_done_fast", 3);
    cyc(6);
    chk("meet_hold", 32'(cnt), 32'd3);

    // Non-one-hot tcode
    tcode = 4'b0011;
    push(4'd0, 15'h0000);
    cyc(1);
    chk("terr_pulse", 32'(terr), 32'd1);
    tcode = 4'b0001;
    cyc(1);
    chk("terr_clear", 32'(terr), 32'd0);
    wait_done("terr_ramp_done", 30);

    // Enable low forces zero
    en = 1'b0; tcode = 4'b1000; ulight = 4'd4;
    cyc(6);
    chk("en_low_count", 32'(cnt), 32'd0);
    chk("en_low_busy", 32'(busy), 32'd0);
    en = 1'b1;
    push(4'd4, 15'h000F);
    wait_done("en_high_done", 30);
    ulight = 4'd12;
    push(4'd12, 15'h0FFF);
    wait_done("to12_done", 60);
    chk("clamp8_count", 32'(cnt8), 32'd8);
    chk("clamp8_lamp", 32'(lamp_en8), 32'h00FF);

    // Async reset mid-ramp at count 5
    ulight = 4'd0;
    wait_cnt("down_reach5", 4'd5, 40);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(cnt), 32'd0);
    chk("arst_lamp", 32'(lamp_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_terr", 32'(terr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4);
    chk("post_rst_count", 32'(cnt), 32'd0);
`else
    // Jump mode: night, 6 lamps
    tcode = 4'b1000; ulight = 4'd6; en = 1'b1;
    push(4'd6, 15'h003F);
    cyc(1);
    chk("jump_lat1", 32'(cnt), 32'd0);
    chk("jump_busy1", 32'(busy), 32'd0);
    cyc(1);
    chk("jump_lat2", 32'(cnt), 32'd6);
    chk("jump_busy2", 32'(busy), 32'd0);
    cyc(2);
    ulight = 4'd2;
    push(4'd2, 15'h0003);
    wait_done("jump_to2", 5);
    cyc(2);

    // Non-one-hot tcode then back to night
    tcode = 4'b0011;
    push(4'd0, 15'h0000);
    push(4'd2, 15'h0003);
    cyc(1);
    chk("terr_pulse", 32'(terr), 32'd1);
    tcode = 4'b1000;
    cyc(1);
    chk("terr_clear", 32'(terr), 32'd0);
    cyc(3);

    // Evening, length 9 -> 2 lamps: unchanged, so no done
    tcode = 4'b0100; length = 4'd9;
    cyc(3);
    chk("eve_count", 32'(cnt), 32'd2);
    tcode = 4'b1000; ulight = 4'd12;
    push(4'd12, 15'h0FFF);
    cyc(4);
    chk("clamp8_count", 32'(cnt8), 32'd8);
    chk("clamp8_lamp", 32'(lamp_en8), 32'h00FF);

    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(cnt), 32'd0);
    chk("arst_lamp", 32'(lamp_en), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    ulight = 4'd0;
    rst_n = 1'b1;
    cyc(4);
    chk("post_rst_count", 32'(cnt), 32'd0);
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_sequencer.md
LAMP_SEQUENCER -- requirements
Module: lamp_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 4: clock cycles between successive single-lamp steps; legal range 1..255.
REQ-002 Parameter MAX_LAMPS, default 15: upper clamp on the target lamp count; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  lighting enable; low forces target to 0.
REQ-006 tcode  input  4  one-hot time code: 0001 morning, 0010 afternoon, 0100 evening, 1000 night.
REQ-007 ulight  input  4  user-requested lamp count, used at night.
REQ-008 length  input  4  square room length.
REQ-009 lamp_en  output  15  thermometer lamp drive; bit i = 1 iff i < active_count.
REQ-010 active_count  output  4  number of lamps currently on.
REQ-011 busy  output  1  high while a ramp is in progress.
REQ-012 done  output  1  one-cycle pulse when active_count reaches target.
REQ-013 tcode_err  output  1  one-cycle pulse for each cycle tcode is not one-hot.

Function
REQ-014 Raw target: morning 0; afternoon 0; evening {2'b00, length[3:2]}; night ulight; any other tcode 0; forced 0 when en=0.
REQ-015 The raw target is clamped to MAX_LAMPS, then registered into target_q; latency from input change to target_q is 1 cycle.
REQ-016 tcode_err is registered alongside target_q, so it shows the same 1-cycle latency.
REQ-017 FSM states: IDLE, RAMP_UP, RAMP_DOWN; busy = (state != IDLE).
REQ-018 IDLE: target_q > active_count -> RAMP_UP; target_q < active_count -> RAMP_DOWN; equal -> stay; on entry to a ramp state, step timer loads STEP_CYCLES-1.
REQ-019 Ramp states: the timer decrements each cycle; at timer==0 active_count moves one toward target_q and the timer reloads STEP_CYCLES-1.
REQ-020 After a step, if new active_count == target_q: go to IDLE and pulse done on the following cycle; else stay in or switch to the ramp state matching the sign of (target_q - active_count).
REQ-021 Target change mid-ramp: if target_q equals active_count on any non-step ramp cycle, go to IDLE immediately, pulse done, and apply no step; a direction reversal takes effect at the next step with no timer reload.
REQ-022 active_count never exceeds MAX_LAMPS, never underflows below 0, and changes by at most 1 per step.
REQ-023 lamp_en, active_count, busy and done are all registered outputs.

Reset
REQ-024 While rst_n=0, regardless of clk: state=IDLE, active_count=0, lamp_en=0, target_q=0, timer=0, busy=0, done=0, tcode_err=0.
REQ-025 Reset asserted mid-ramp: all lamps go off immediately; no done pulse is generated.
REQ-026 After reset deassertion, operation resumes from IDLE on the first rising clk edge.

Configuration
REQ-027 Macro LAMP_SEQ_RAMP_EN defined: soft ramping per REQ-018..REQ-021.
REQ-028 Macro LAMP_SEQ_RAMP_EN undefined: active_count loads target_q on the cycle after target_q changes; busy stays 0; done pulses on every such load; STEP_CYCLES is ignored.

Verification (STEP_CYCLES=4, MAX_LAMPS=15, macro defined unless noted)
REQ-029 Assert rst_n=0 asynchronously during a ramp at active_count=5 -> all outputs 0 within the same cycle, with no clock edge required.
REQ-030 Set tcode=1000, ulight=3, en=1 from count 0 -> busy rises 2 cycles later; count steps 1,2,3 four cycles apart; lamp_en=15'h0007; a single done pulse; busy=0.
REQ-031 Set tcode=0100, length=9 -> target 2, count ramps to 2, lamp_en=15'h0003; then set tcode=0001 -> count ramps down to 0 with a single done pulse.
REQ-032 Night with ulight=5: at active_count=3, drop ulight to 2 -> next step goes to 2, done pulses, state returns to IDLE, no overshoot.
REQ-033 Set tcode=0011 for 1 cycle -> tcode_err pulses 1 cycle late and target is 0; with MAX_LAMPS=8 and ulight=12 -> count settles at 8, lamp_en=15'h00FF.
REQ-034 Macro undefined, tcode=1000, ulight=6 -> active_count=6 two cycles after the input change, busy never set, done pulses once.
